// File: rtl/zjh_mod_down_counter.sv
// Synchronous presettable modulo-MODULUS down counter with cascade borrow,
// registered wrap pulse and registered clamped-load error flag.
module zjh_mod_down_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 14
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             PE,
  input  logic             CEP,
  input  logic             CET,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             B,
  output logic             W,
  output logic             LERR
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  // One extra bit so MODULUS == 2**WIDTH compares correctly (never out of range).
  function automatic logic load_out_of_range(input logic [WIDTH-1:0] d);
    return ({1'b0, d} >= MOD_EXT);
  endfunction

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
    return load_out_of_range(d) ? MAX_Q : d;
  endfunction

  logic             count_en;
  logic             at_zero;
  logic [WIDTH-1:0] q_nxt;
  logic             w_nxt;
  logic             lerr_nxt;

  assign count_en = CEP & CET;
  assign at_zero  = (Q == '0);

  always_comb begin
    q_nxt    = Q;
    w_nxt    = 1'b0;
    lerr_nxt = 1'b0;
    if (PE) begin
      q_nxt    = clamp_load(D);
      lerr_nxt = load_out_of_range(D);
    end else if (count_en) begin
      if (at_zero) begin
        q_nxt = MAX_Q;
        w_nxt = 1'b1;
      end else begin
        q_nxt = Q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (MR) begin
      Q    <= '0;
      W    <= 1'b0;
      LERR <= 1'b0;
    end else begin
      Q    <= q_nxt;
      W    <= w_nxt;
      LERR <= lerr_nxt;
    end
  end

  // Borrow qualifies on CET only so a cascade ripples through stages like TC.
  assign B = at_zero & CET;

endmodule

// File: doc/zjh_mod_down_counter.md
Name: zjh_mod_down_counter

Overview:
- Synchronous presettable modulo-N down counter. It is the count-down counterpart to the team's mod-14 up-counter built on the 74HC161 model, which counts 0..13 and clears on terminal count.
- Counts MODULUS-1 down to 0, then wraps.
- Provides a combinational borrow output for cascading and a registered wrap pulse.
- Used as a countdown timer, or as a reverse sequencer alongside the up-counter in the counter-experiment designs.

Parameters:
WIDTH, 4, counter width in bits
MODULUS, 14, count length; legal range 2..2^WIDTH; states are 0..MODULUS-1

Ports:
Clk  input  1  rising-edge clock
MR  input  1  master reset, synchronous, active-high
PE  input  1  parallel load enable, active-high, synchronous
CEP  input  1  count enable (parallel), active-high
CET  input  1  count enable (trickle/cascade), active-high
D  input  WIDTH  parallel load data
Q  output  WIDTH  current count
B  output  1  borrow/terminal count, combinational: (Q == 0) & CET
W  output  1  registered wrap pulse; high for one cycle after a 0 -> MODULUS-1 count transition
LERR  output  1  registered; high for one cycle after a load whose D >= MODULUS was clamped

Behaviour:
- Reset is synchronous and active-high on MR. Only the rising edge of Clk is used.
- Reset values: Q=0, W=0, LERR=0. B follows Q and CET combinationally, so B=CET during reset.
- Priority at each rising edge of Clk, highest first: MR, then PE, then count (CEP & CET), then hold.
- MR=1: Q<=0, W<=0, LERR<=0. PE, CEP, CET and D are ignored.
- PE=1 (MR=0), normal load: if D <= MODULUS-1, Q<=D and LERR<=0.
- PE=1 (MR=0), clamped load: if D >= MODULUS, Q<=MODULUS-1 and LERR<=1.
- PE=1 (MR=0): W<=0. Load overrides counting even when CEP=CET=1.
- Count (PE=0, CEP=1, CET=1), Q != 0: Q<=Q-1, W<=0.
- Count (PE=0, CEP=1, CET=1), Q == 0: Q<=MODULUS-1 (wrap), W<=1.
- Hold (PE=0 and either CEP=0 or CET=0): Q unchanged, W<=0.
- LERR<=0 on every edge that is not a clamped load.
- Latency: Q updates 1 cycle after the qualifying edge. W and LERR are asserted in the same cycle as the new Q value. B is 0-latency combinational.
- Cascading: tie the upper stage's CET to the lower stage's B, and drive both stages with a common CEP.
  - The upper stage decrements exactly when the lower stage wraps.
  - B uses CET, not CEP, as in the 74HC161 TC convention.
- MODULUS = 2^WIDTH: wrap is the natural underflow. The clamp can never trigger, so LERR stays 0.
- No illegal states are reachable: load is clamped and reset gives 0. Out-of-range Q is impossible, so no recovery logic is required.
- Reset mid-count or mid-load: MR wins on that edge. The next non-reset edge behaves from Q=0.
- All outputs are driven from flops or simple decode. No latches and no gated clocks.

Test Plan:
- Reset, then count: MR=1 for 2 cycles (Q=0, W=0, B=CET) -> release with CEP=CET=1. Expect Q=13, W=1, then Q=12..0 with W=0, then Q=13 with W=1 again; period is 14 cycles.
- Load: D=5, PE=1 for 1 cycle, CEP=CET=1 -> Q=5, then 4,3,2,1,0. B=1 while Q=0, then Q wraps to 13.
- Clamp: D=15, PE=1 -> Q=13, LERR=1 for exactly one cycle. Then D=13, PE=1 -> Q=13, LERR=0.
- Enables and priority:
  - CEP=0, CET=1 at Q=7 -> Q holds at 7, B=0.
  - CET=0 at Q=0 -> B=0 and Q holds.
  - PE=1 with CEP=CET=1, D=3 -> Q=3 (load wins).
- Reset priority: during counting at Q=9, assert MR with PE=1 and D=4 -> Q=0 next cycle, W=0, LERR=0.
- Cascade: two instances (WIDTH=4, MODULUS=10, low stage's B driving high stage's CET), both loaded with 0, CEP=1 -> combined sequence 99, 98, ..., 00, 99. The high stage decrements only on the edge where the low stage goes 0 -> 9.
